llc_req_sequencer: RTL
======================

// Module: llc_req_sequencer
// PURPOSE
// - Front-end controller for the LLC tag/MESI/PLRU core. Arbitrates between two requesters:
//   the L1 port (trace cmds 0,1,2,8,9) and the snoop port (cmds 3-6).
// - Serialises requests so the core sees exactly one transaction at a time.
// - Tracks each transaction through issue and completion, with a watchdog on completion.
// - Sits between the trace handler / bus model and the LLC core.
// PARAMETERS
// - ADDR_BITS       32  address width (from shared package)
// - CMDSIZE         4   command width (from shared package)
// - SNP_STREAK_MAX  4   max consecutive snoop grants while L1 waits; range 1..15
// - TIMEOUT_CYCLES  64  cycles WAIT may last before abort; range 2..1023
// PORTS
// - clk             in   1          clock; all state changes on posedge
// - rst             in   1          synchronous, active-high reset
// - l1_valid        in   1          L1 request valid
// - l1_ready        out  1          L1 request accepted this cycle
// - l1_cmd          in   CMDSIZE    L1 command
// - l1_addr         in   ADDR_BITS  L1 address
// - snp_valid       in   1          snoop request valid
// - snp_ready       out  1          snoop request accepted this cycle
// - snp_cmd         in   CMDSIZE    snoop command
// - snp_addr        in   ADDR_BITS  snoop address
// - llc_req_valid   out  1          request to core valid
// - llc_req_ready   in   1          core takes request
// - llc_req_cmd     out  CMDSIZE    latched command
// - llc_req_addr    out  ADDR_BITS  latched address
// - llc_req_src     out  1          0 = L1, 1 = snoop
// - llc_done        in   1          core completion pulse
// - busy            out  1          state != IDLE
// - err_badcmd      out  1          1-cycle pulse: illegal cmd accepted and dropped
// - err_timeout     out  1          sticky; cleared only by rst
// - l1_grants       out  32         count of L1 requests forwarded to the core
// - snp_grants      out  32         count of snoop requests forwarded to the core
// BEHAVIOUR
// - Reset values: all outputs 0, state = IDLE, snoop streak = 0, holding registers = 0.
// - Handshake: transfer occurs when valid && ready. A requester holds valid and payload stable
//   until ready. Ready is combinational, asserted only in IDLE, and only for the winner. Only
//   one ready is high in any cycle.
// - Arbitration in IDLE:
//   - Snoop wins over L1, except when streak == SNP_STREAK_MAX and l1_valid; then L1 wins.
//   - Streak increments on a snoop grant while l1_valid = 1.
//   - Streak clears on an L1 grant, or when l1_valid = 0.
//   - Streak saturates at SNP_STREAK_MAX.
// - Legality check on accept:
//   - L1 legal: {0,1,2,8,9}. Snoop legal: {3,4,5,6}.
//   - Illegal cmd: accepted (ready = 1), err_badcmd pulses the next cycle, FSM stays IDLE,
//     no grant is counted, streak is unchanged.
// - FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//   - IDLE: on a legal accept, latch cmd/addr/src; go to ISSUE the next cycle.
//   - ISSUE: llc_req_valid = 1, held until llc_req_ready. On llc_req_ready, the grant counter
//     for src increments and the FSM goes to WAIT.
//   - WAIT: on llc_done, go to IDLE. The next accept is possible in the cycle after return
//     to IDLE. Minimum turnaround: accept -> ISSUE (cycle 1) -> WAIT (cycle 2) -> IDLE
//     (cycle 3); 3 cycles/request with zero-latency core.
//   - Timeout: the WAIT counter resets on entry. If it reaches TIMEOUT_CYCLES without
//     llc_done, set err_timeout and go to IDLE. The transaction is abandoned and the grant
//     count is not reverted.
//   - llc_done outside WAIT is ignored.
//   - llc_done in the same cycle as the timeout expiry counts as completion; no error.
// - Commands 8 (clear) and 9 (print) follow the same path; no special ordering.
// - Counters wrap at 2^32 to 0.
// - rst mid-transaction: abandons the transaction immediately, returns to IDLE, and clears
//   counters and errors. llc_req_valid = 0 in the cycle after rst.
// STRUCTURE
// - Shared package llc_pkg:
//   - ADDR_BITS, CMDSIZE
//   - cmd_t enum (READ_L1D=0, WRITE_L1D=1, READ_L1I=2, SNP_INV=3, SNP_RD=4, SNP_WR=5,
//     SNP_RWIM=6, CLR=8, PRINT=9)
//   - seq_state_t {IDLE, ISSUE, WAIT}
// - One sub-module, llc_grant_arb: combinational winner select from l1_valid, snp_valid and
//   streak_at_max, plus the registered streak counter.
// - FSM, holding registers, watchdog and counters live in the top.
// TESTING
// - L1 only: l1 cmd 0 @0x0000_1040, core ready = 1, done 1 cycle after issue ->
//   l1_ready 1 cycle, llc_req_src = 0, l1_grants = 1, busy for 3 cycles.
// - Both valid in IDLE: snp cmd 4 @0x40 and l1 cmd 1 @0x80 -> snoop granted first;
//   L1 granted on the next IDLE.
// - Starvation: snp_valid held with cmd 3, l1 cmd 0 held, SNP_STREAK_MAX = 4 ->
//   grants S,S,S,S,L,S,S,S,S,L.
// - Illegal cmds: l1 cmd 5 -> err_badcmd pulse, l1_grants = 0, no llc_req_valid;
//   snp cmd 8 -> same.
// - Timeout: llc_done never asserted, TIMEOUT_CYCLES = 64 -> err_timeout = 1 at cycle 64
//   of WAIT; next request accepted afterwards.
// - Backpressure and reset: llc_req_ready low 10 cycles -> llc_req_valid/cmd/addr stable.
//   rst in WAIT -> next cycle IDLE, all outputs 0.

Source files
------------

// File: rtl/llc_pkg.sv
// Shared types and constants for the LLC front-end.
// Contents: address/command widths, trace command encoding, sequencer
// state encoding, and per-port command legality helpers.
package llc_pkg;

    localparam int ADDR_BITS = 32;
    localparam int CMDSIZE   = 4;

    typedef enum logic [CMDSIZE-1:0] {
        READ_L1D  = 4'd0,
        WRITE_L1D = 4'd1,
        READ_L1I  = 4'd2,
        SNP_INV   = 4'd3,
        SNP_RD    = 4'd4,
        SNP_WR    = 4'd5,
        SNP_RWIM  = 4'd6,
        CLR       = 4'd8,
        PRINT     = 4'd9
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    // Commands the L1 side may legally issue.
    function automatic logic l1_cmd_legal(input logic [CMDSIZE-1:0] c);
        case (c)
            READ_L1D, WRITE_L1D, READ_L1I, CLR, PRINT: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    // Commands the snoop side may legally issue.
    function automatic logic snp_cmd_legal(input logic [CMDSIZE-1:0] c);
        case (c)
            SNP_INV, SNP_RD, SNP_WR, SNP_RWIM: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/llc_grant_arb.sv
// Grant selection between the L1 and snoop requesters, with an anti-starvation
// streak counter that lets L1 through after SNP_STREAK_MAX snoop wins in a row.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   idle_i              sequencer can accept this cycle
//   l1_valid_i          L1 request pending
//   snp_valid_i         snoop request pending
//   l1_legal_i          pending L1 command is legal
//   snp_legal_i         pending snoop command is legal
//   gnt_l1_o, gnt_snp_o one-hot (or zero) grant; doubles as the ready
module llc_grant_arb #(
    parameter int SNP_STREAK_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic idle_i,
    input  logic l1_valid_i,
    input  logic snp_valid_i,
    input  logic l1_legal_i,
    input  logic snp_legal_i,
    output logic gnt_l1_o,
    output logic gnt_snp_o
);

    localparam logic [3:0] STREAK_MAX = 4'(SNP_STREAK_MAX);

    logic [3:0] streak_q, streak_d;
    logic       streak_at_max;

    assign streak_at_max = (streak_q == STREAK_MAX);

    always_comb begin
        gnt_snp_o = idle_i && snp_valid_i && !(streak_at_max && l1_valid_i);
        gnt_l1_o  = idle_i && l1_valid_i && !gnt_snp_o;
    end

    // Illegal commands are dropped without touching the streak; only a
    // forwarded snoop while L1 waits counts toward starvation.
    always_comb begin
        streak_d = streak_q;
        if (!l1_valid_i)
            streak_d = '0;
        else if (gnt_l1_o && l1_legal_i)
            streak_d = '0;
        else if (gnt_snp_o && snp_legal_i && !streak_at_max)
            streak_d = streak_q + 4'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) streak_q <= '0;
        else       streak_q <= streak_d;
    end

endmodule

// File: rtl/llc_req_sequencer.sv
// Front-end controller for the LLC core: arbitrates L1 vs snoop requests,
// serialises them into one outstanding core transaction, and watches for
// completion with a timeout.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   l1_valid_i/l1_ready_o/l1_cmd_i/l1_addr_i       L1 request handshake
//   snp_valid_i/snp_ready_o/snp_cmd_i/snp_addr_i   snoop request handshake
//   llc_req_valid_o/llc_req_ready_i  request handshake toward the core
//   llc_req_cmd_o/addr_o/src_o       latched request (src 0 = L1, 1 = snoop)
//   llc_done_i                       core completion pulse
//   busy_o                           transaction in flight
//   err_badcmd_o                     one-cycle pulse: illegal command dropped
//   err_timeout_o                    sticky: completion never arrived
//   l1_grants_o, snp_grants_o        forwarded-request counters
module llc_req_sequencer
    import llc_pkg::*;
#(
    parameter int SNP_STREAK_MAX = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 l1_valid_i,
    output logic                 l1_ready_o,
    input  logic [CMDSIZE-1:0]   l1_cmd_i,
    input  logic [ADDR_BITS-1:0] l1_addr_i,
    input  logic                 snp_valid_i,
    output logic                 snp_ready_o,
    input  logic [CMDSIZE-1:0]   snp_cmd_i,
    input  logic [ADDR_BITS-1:0] snp_addr_i,
    output logic                 llc_req_valid_o,
    input  logic                 llc_req_ready_i,
    output logic [CMDSIZE-1:0]   llc_req_cmd_o,
    output logic [ADDR_BITS-1:0] llc_req_addr_o,
    output logic                 llc_req_src_o,
    input  logic                 llc_done_i,
    output logic                 busy_o,
    output logic                 err_badcmd_o,
    output logic                 err_timeout_o,
    output logic [31:0]          l1_grants_o,
    output logic [31:0]          snp_grants_o
);

    localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT_CYCLES - 1);

    seq_state_t           state_q, state_d;
    logic [CMDSIZE-1:0]   cmd_q, cmd_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 src_q, src_d;
    logic [9:0]           wdog_q, wdog_d;
    logic                 bad_q, bad_d;
    logic                 to_q, to_d;
    logic [31:0]          l1_cnt_q, l1_cnt_d;
    logic [31:0]          snp_cnt_q, snp_cnt_d;

    logic gnt_l1, gnt_snp, l1_legal, snp_legal;

    assign l1_legal  = l1_cmd_legal(l1_cmd_i);
    assign snp_legal = snp_cmd_legal(snp_cmd_i);

    llc_grant_arb #(.SNP_STREAK_MAX(SNP_STREAK_MAX)) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idle_i      (state_q == IDLE),
        .l1_valid_i  (l1_valid_i),
        .snp_valid_i (snp_valid_i),
        .l1_legal_i  (l1_legal),
        .snp_legal_i (snp_legal),
        .gnt_l1_o    (gnt_l1),
        .gnt_snp_o   (gnt_snp)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        src_d     = src_q;
        wdog_d    = wdog_q;
        bad_d     = 1'b0;
        to_d      = to_q;
        l1_cnt_d  = l1_cnt_q;
        snp_cnt_d = snp_cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt_snp) begin
                    if (snp_legal) begin
                        cmd_d   = snp_cmd_i;
                        addr_d  = snp_addr_i;
                        src_d   = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        bad_d = 1'b1;
                    end
                end else if (gnt_l1) begin
                    if (l1_legal) begin
                        cmd_d   = l1_cmd_i;
                        addr_d  = l1_addr_i;
                        src_d   = 1'b0;
                        state_d = ISSUE;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (llc_req_ready_i) begin
                    if (src_q) snp_cnt_d = snp_cnt_q + 32'd1;
                    else       l1_cnt_d  = l1_cnt_q + 32'd1;
                    wdog_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Completion on the expiry cycle still wins over the timeout.
                if (llc_done_i) begin
                    state_d = IDLE;
                end else if (wdog_q == WDOG_LAST) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            addr_q    <= '0;
            src_q     <= 1'b0;
            wdog_q    <= '0;
            bad_q     <= 1'b0;
            to_q      <= 1'b0;
            l1_cnt_q  <= '0;
            snp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            src_q     <= src_d;
            wdog_q    <= wdog_d;
            bad_q     <= bad_d;
            to_q      <= to_d;
            l1_cnt_q  <= l1_cnt_d;
            snp_cnt_q <= snp_cnt_d;
        end
    end

    assign l1_ready_o      = gnt_l1;
    assign snp_ready_o     = gnt_snp;
    assign llc_req_valid_o = (state_q == ISSUE);
    assign llc_req_cmd_o   = cmd_q;
    assign llc_req_addr_o  = addr_q;
    assign llc_req_src_o   = src_q;
    assign busy_o          = (state_q != IDLE);
    assign err_badcmd_o    = bad_q;
    assign err_timeout_o   = to_q;
    assign l1_grants_o     = l1_cnt_q;
    assign snp_grants_o    = snp_cnt_q;

endmodule
